// File: rtl/freq_frame_buffer.sv
// freq_frame_buffer
// Assembles in-order FFT magnitude frames into a ping-pong RAM, tracks the
// peak bin of each frame and presents a stable, fully written frame to the
// display reader. The bank swap is held off while the reader is locked.
module freq_frame_buffer #(
   parameter int ADDR_W = 9
) (
   input  logic              ckFreq,
   input  logic              btnL,
   input  logic              flgFreqSampleValid,
   input  logic [9:0]        addrFreq,
   input  logic [7:0]        byteFreqSample,
   input  logic              rdLock,
   input  logic [ADDR_W-1:0] rdAddr,
   output logic [7:0]        rdData,
   output logic              bankRd,
   output logic              flgFrameReady,
   output logic [ADDR_W-1:0] peakBin,
   output logic [7:0]        peakVal,
   output logic [7:0]        cntSyncError,
   output logic [7:0]        cntFrameDropped
);

   localparam int NUM_BINS = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      stSync    = 2'd0,
      stCapture = 2'd1,
      stPending = 2'd2
   } state_t;

   // Storage: lower half is bank 0, upper half is bank 1
   logic [7:0]        r_mem [0:2*NUM_BINS-1];

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_expected;
   logic [7:0]        r_run_peak_val;
   logic [ADDR_W-1:0] r_run_peak_bin;
   logic              r_bank_rd;
   logic [7:0]        r_rd_data;
   logic              r_frame_ready;
   logic [ADDR_W-1:0] r_peak_bin;
   logic [7:0]        r_peak_val;
   logic [7:0]        r_cnt_sync_err;
   logic [7:0]        r_cnt_drop;

   logic              w_we;
   logic              w_start;
   logic              w_accept;
   logic              w_swap;
   logic              w_sync_err;
   logic              w_drop;
   logic [ADDR_W:0]   w_waddr;
   logic [7:0]        w_cand_val;
   logic [ADDR_W-1:0] w_cand_bin;

   // Writes always go to the bank the reader is not looking at
   assign w_waddr = {~r_bank_rd, addrFreq[ADDR_W-1:0]};

   // Write FSM next-state and per-cycle control strobes
   always_comb begin
      w_next_state = r_state;
      w_we         = 1'b0;
      w_start      = 1'b0;
      w_accept     = 1'b0;
      w_swap       = 1'b0;
      w_sync_err   = 1'b0;
      w_drop       = 1'b0;
      case (r_state)
         stSync: begin
            if (flgFreqSampleValid && (addrFreq == 10'd0)) begin
               w_we         = 1'b1;
               w_start      = 1'b1;
               w_next_state = stCapture;
            end else begin
               w_next_state = stSync;
            end
         end
         stCapture: begin
            if (flgFreqSampleValid) begin
               if (addrFreq == {1'b0, r_expected}) begin
                  w_we     = 1'b1;
                  w_accept = 1'b1;
                  if (&r_expected) begin
                     if (!rdLock) begin
                        w_swap       = 1'b1;
                        w_next_state = stSync;
                     end else begin
                        w_next_state = stPending;
                     end
                  end else begin
                     w_next_state = stCapture;
                  end
               end else begin
                  // Out-of-order address: abort; this sample never starts a frame
                  w_sync_err   = 1'b1;
                  w_next_state = stSync;
               end
            end else begin
               w_next_state = stCapture;
            end
         end
         stPending: begin
            if (flgFreqSampleValid && (addrFreq == 10'd0)) begin
               w_drop = 1'b1;
            end else begin
               w_drop = 1'b0;
            end
            if (!rdLock) begin
               w_swap       = 1'b1;
               w_next_state = stSync;
            end else begin
               w_next_state = stPending;
            end
         end
         default: begin
            w_next_state = stSync;
         end
      endcase
   end

   // Running peak including the sample accepted this cycle; strict compare keeps the lowest bin on ties
   always_comb begin
      w_cand_val = r_run_peak_val;
      w_cand_bin = r_run_peak_bin;
      if (w_accept && (byteFreqSample > r_run_peak_val)) begin
         w_cand_val = byteFreqSample;
         w_cand_bin = r_expected;
      end else begin
         w_cand_val = r_run_peak_val;
         w_cand_bin = r_run_peak_bin;
      end
   end

   // FSM state, expected bin and running peak registers
   always_ff @(posedge ckFreq or posedge btnL) begin
      if (btnL) begin
         r_state        <= stSync;
         r_expected     <= {ADDR_W{1'b0}};
         r_run_peak_val <= 8'd0;
         r_run_peak_bin <= {ADDR_W{1'b0}};
      end else begin
         r_state <= w_next_state;
         if (w_start) begin
            r_expected     <= {{(ADDR_W-1){1'b0}}, 1'b1};
            r_run_peak_val <= byteFreqSample;
            r_run_peak_bin <= {ADDR_W{1'b0}};
         end else if (w_accept) begin
            r_expected     <= r_expected + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_run_peak_val <= w_cand_val;
            r_run_peak_bin <= w_cand_bin;
         end
      end
   end

   // Bank swap, frame-ready pulse and presented peak
   always_ff @(posedge ckFreq or posedge btnL) begin
      if (btnL) begin
         r_bank_rd     <= 1'b0;
         r_frame_ready <= 1'b0;
         r_peak_bin    <= {ADDR_W{1'b0}};
         r_peak_val    <= 8'd0;
      end else begin
         r_frame_ready <= w_swap;
         if (w_swap) begin
            r_bank_rd  <= ~r_bank_rd;
            r_peak_bin <= w_cand_bin;
            r_peak_val <= w_cand_val;
         end
      end
   end

   // Saturating error counters
   always_ff @(posedge ckFreq or posedge btnL) begin
      if (btnL) begin
         r_cnt_sync_err <= 8'd0;
         r_cnt_drop     <= 8'd0;
      end else begin
         if (w_sync_err && (r_cnt_sync_err != 8'hFF)) begin
            r_cnt_sync_err <= r_cnt_sync_err + 8'd1;
         end
         if (w_drop && (r_cnt_drop != 8'hFF)) begin
            r_cnt_drop <= r_cnt_drop + 8'd1;
         end
      end
   end

   // RAM write port; contents are intentionally not reset
   always_ff @(posedge ckFreq) begin
      if (w_we) begin
         r_mem[w_waddr] <= byteFreqSample;
      end
   end

   // Registered read port from the presented bank
   always_ff @(posedge ckFreq or posedge btnL) begin
      if (btnL) begin
         r_rd_data <= 8'd0;
      end else begin
         r_rd_data <= r_mem[{r_bank_rd, rdAddr}];
      end
   end

   assign rdData          = r_rd_data;
   assign bankRd          = r_bank_rd;
   assign flgFrameReady   = r_frame_ready;
   assign peakBin         = r_peak_bin;
   assign peakVal         = r_peak_val;
   assign cntSyncError    = r_cnt_sync_err;
   assign cntFrameDropped = r_cnt_drop;

endmodule

// File: tb/tb_freq_frame_buffer.sv
// tb_freq_frame_buffer
// Directed bench for freq_frame_buffer with hand-computed expectations.
`timescale 1ns/1ps
module tb_freq_frame_buffer;

   logic       ckFreq;
   logic       btnL;
   logic       flgFreqSampleValid;
   logic [9:0] addrFreq;
   logic [7:0] byteFreqSample;
   logic       rdLock;
   logic [8:0] rdAddr;
   logic [7:0] rdData;
   logic       bankRd;
   logic       flgFrameReady;
   logic [8:0] peakBin;
   logic [7:0] peakVal;
   logic [7:0] cntSyncError;
   logic [7:0] cntFrameDropped;

   int n_cmp  = 0;
   int n_err  = 0;
   int n_puls = 0;
   int p0;

   freq_frame_buffer #(.ADDR_W(9)) u_dut (
      .ckFreq            (ckFreq),
      .btnL              (btnL),
      .flgFreqSampleValid(flgFreqSampleValid),
      .addrFreq          (addrFreq),
      .byteFreqSample    (byteFreqSample),
      .rdLock            (rdLock),
      .rdAddr            (rdAddr),
      .rdData            (rdData),
      .bankRd            (bankRd),
      .flgFrameReady     (flgFrameReady),
      .peakBin           (peakBin),
      .peakVal           (peakVal),
      .cntSyncError      (cntSyncError),
      .cntFrameDropped   (cntFrameDropped)
   );

   initial ckFreq = 1'b0;
   always #5 ckFreq = ~ckFreq;

   // Count frame-ready pulses, sampled away from the active edge
   always @(negedge ckFreq) begin
      if (flgFrameReady === 1'b1) n_puls = n_puls + 1;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; land 1ns after the rising edge
   task automatic tick();
      @(posedge ckFreq);
      #1;
   endtask

   function automatic logic [7:0] pat_byte(input int pat, input int bin);
      logic [9:0] b;
      b = bin[9:0];
      case (pat)
         0: pat_byte = b[7:0] ^ 8'h5A;
         1: pat_byte = ((b == 10'd7) || (b == 10'd300)) ? 8'hC0 : (b[7:0] & 8'h7F);
         2: pat_byte = (b == 10'd200) ? 8'h80 : 8'h10;
         default: pat_byte = 8'hFE;
      endcase
   endfunction

   task automatic send_sample(input int addr, input logic [7:0] data);
      flgFreqSampleValid = 1'b1;
      addrFreq           = addr[9:0];
      byteFreqSample     = data;
      tick();
      flgFreqSampleValid = 1'b0;
   endtask

   task automatic send_frame(input int pat, input int gap, input int nbins);
      for (int i = 0; i < nbins; i++) begin
         send_sample(i, pat_byte(pat, i));
         if (gap != 0 && i != nbins - 1) tick();
      end
   endtask

   task automatic read_all(input int pat, input string tag);
      for (int a = 0; a < 512; a++) begin
         rdAddr = a[8:0];
         tick();
         check(tag, rdData, pat_byte(pat, a));
      end
   endtask

   initial begin
      btnL = 1'b1;
      flgFreqSampleValid = 1'b0;
      addrFreq = 10'd0;
      byteFreqSample = 8'd0;
      rdLock = 1'b0;
      rdAddr = 9'd0;
      repeat (3) tick();

      // Reset state
      check("rst_bank", bankRd, 0);
      check("rst_rd", rdData, 0);
      check("rst_rdy", flgFrameReady, 0);
      check("rst_pbin", peakBin, 0);
      check("rst_pval", peakVal, 0);
      check("rst_sync", cntSyncError, 0);
      check("rst_drop", cntFrameDropped, 0);
      btnL = 1'b0;
      tick();

      // In-order frame, reader unlocked
      p0 = n_puls;
      send_frame(0, 0, 512);
      check("f1_rdy", flgFrameReady, 1);
      check("f1_bank", bankRd, 1);
      check("f1_pval", peakVal, 8'hFF);
      check("f1_pbin", peakBin, 165);
      tick();
      check("f1_rdy_lo", flgFrameReady, 0);
      check("f1_npuls", n_puls - p0, 1);
      read_all(0, "f1_rd");

      // Same frame with gaps between samples
      p0 = n_puls;
      send_frame(0, 1, 512);
      check("f2_bank", bankRd, 0);
      check("f2_pval", peakVal, 8'hFF);
      check("f2_pbin", peakBin, 165);
      tick();
      check("f2_npuls", n_puls - p0, 1);
      check("f2_sync", cntSyncError, 0);
      read_all(0, "f2_rd");

      // Address skip aborts the frame
      p0 = n_puls;
      send_frame(3, 0, 100);
      send_sample(101, 8'hFE);
      tick();
      check("skip_sync", cntSyncError, 1);
      check("skip_npuls", n_puls - p0, 0);
      check("skip_bank", bankRd, 0);

      // Clean frame after abort, with a tied peak at bins 7 and 300
      send_frame(1, 0, 512);
      check("tie_bank", bankRd, 1);
      check("tie_pval", peakVal, 8'hC0);
      check("tie_pbin", peakBin, 7);
      tick();
      check("tie_npuls", n_puls - p0, 1);

      // Reader locked across completion and two new frame starts
      p0 = n_puls;
      rdLock = 1'b1;
      send_frame(2, 0, 512);
      send_sample(0, 8'hFF);
      send_sample(5, 8'hFF);
      send_sample(0, 8'hFF);
      tick();
      check("lock_drop", cntFrameDropped, 2);
      check("lock_npuls", n_puls - p0, 0);
      check("lock_bank", bankRd, 1);
      check("lock_pval", peakVal, 8'hC0);
      rdLock = 1'b0;
      tick();
      check("unlk_rdy", flgFrameReady, 1);
      check("unlk_bank", bankRd, 0);
      check("unlk_pval", peakVal, 8'h80);
      check("unlk_pbin", peakBin, 200);
      rdAddr = 9'd200;
      tick();
      check("unlk_rd200", rdData, 8'h80);
      rdAddr = 9'd0;
      tick();
      check("unlk_rd0", rdData, 8'h10);

      // Asynchronous reset in the middle of a frame
      send_frame(0, 0, 250);
      flgFreqSampleValid = 1'b1;
      addrFreq = 10'd250;
      byteFreqSample = pat_byte(0, 250);
      #2;
      btnL = 1'b1;
      #1;
      check("arst_bank", bankRd, 0);
      check("arst_rd", rdData, 0);
      check("arst_rdy", flgFrameReady, 0);
      check("arst_pbin", peakBin, 0);
      check("arst_pval", peakVal, 0);
      check("arst_sync", cntSyncError, 0);
      check("arst_drop", cntFrameDropped, 0);
      tick();
      flgFreqSampleValid = 1'b0;
      btnL = 1'b0;
      tick();
      p0 = n_puls;
      send_frame(0, 0, 512);
      repeat (4) tick();
      check("post_npuls", n_puls - p0, 1);
      check("post_bank", bankRd, 1);
      check("post_pval", peakVal, 8'hFF);
      check("post_pbin", peakBin, 165);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
